// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end for the 5-stage MIPS pipeline.
// Owns the fetch PC, drives a synchronous instruction ROM, and buffers the
// returned words in a small FIFO ahead of the IF/ID latch. A taken branch
// from MEM flushes everything buffered or in flight and reloads the PC.
// Optional feature macro: FETCH_PERF_EN adds perf_fetch / perf_flush counters.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter int          AW       = 10,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          redirect,
   input  logic [31:0]   redirect_pc,
   output logic [AW-1:0] rom_addr,
   input  logic [31:0]   rom_data,
   input  logic          id_ready,
   output logic          id_valid,
   output logic [31:0]   id_instr,
   output logic [31:0]   id_next_pc,
   output logic [31:0]   fetch_pc
`ifdef FETCH_PERF_EN
  ,output logic [31:0]   perf_fetch,
   output logic [15:0]   perf_flush
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]   pc;
   logic          req_v;
   logic [31:0]   req_pc;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [31:0]   mem_instr [DEPTH];
   logic [31:0]   mem_npc   [DEPTH];

   logic [CW:0]   credit;
   logic          issue;
   logic          push;
   logic          pop;

   // Credit uses registered count and in-flight flag only; a same-cycle pop
   // frees space one cycle later, which keeps rom_data off the issue path.
   assign credit = {1'b0, count} + {{CW{1'b0}}, req_v};
   assign issue  = !redirect && (credit < (CW+1)'(DEPTH));
   assign push   = req_v && !redirect;
   assign pop    = id_valid && id_ready && !redirect;

   assign rom_addr   = pc[AW+1:2];
   assign fetch_pc   = pc;
   assign id_valid   = (count != '0);
   assign id_instr   = id_valid ? mem_instr[rd_ptr] : 32'h0;
   assign id_next_pc = id_valid ? mem_npc[rd_ptr]   : 32'h0;

   // PC and in-flight request slot; redirect overrides any issue.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc     <= RESET_PC;
         req_v  <= 1'b0;
         req_pc <= 32'h0;
      end else if (redirect) begin
         pc     <= redirect_pc & 32'hFFFF_FFFC;
         req_v  <= 1'b0;
      end else if (issue) begin
         req_v  <= 1'b1;
         req_pc <= pc;
         pc     <= pc + 32'd4;
      end else begin
         req_v  <= 1'b0;
      end
   end

   // FIFO pointers and occupancy; flush on redirect discards all entries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage written with the returning ROM word and its PC+4.
   // NOTE: storage has no reset; outputs are gated by id_valid, so stale
   // contents are never visible and the array can map to plain RAM/flops.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_instr[wr_ptr] <= rom_data;
         mem_npc[wr_ptr]   <= req_pc + 32'd4;
      end
   end

`ifdef FETCH_PERF_EN
   // Delivered-instruction counter (wraps) and saturating redirect counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch <= 32'h0;
         perf_flush <= 16'h0;
      end else begin
         if (pop) perf_fetch <= perf_fetch + 32'd1;
         if (redirect && (perf_flush != 16'hFFFF)) perf_flush <= perf_flush + 16'd1;
      end
   end
`else
   // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue.
// ROM model returns 32'h1000_0000 + word address one cycle after the address.
`timescale 1ns/1ps
module tb_fetch_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          redirect;
   logic [31:0]   redirect_pc;
   logic [AW-1:0] rom_addr;
   logic [31:0]   rom_data;
   logic          id_ready;
   logic          id_valid;
   logic [31:0]   id_instr;
   logic [31:0]   id_next_pc;
   logic [31:0]   fetch_pc;
`ifdef FETCH_PERF_EN
   logic [31:0]   perf_fetch;
   logic [15:0]   perf_flush;
`endif

   int checks   = 0;
   int failures = 0;

   fetch_queue #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(32'h0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .id_ready   (id_ready),
      .id_valid   (id_valid),
      .id_instr   (id_instr),
      .id_next_pc (id_next_pc),
      .fetch_pc   (fetch_pc)
`ifdef FETCH_PERF_EN
     ,.perf_fetch (perf_fetch),
      .perf_flush (perf_flush)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous ROM model.
   always @(posedge clk) rom_data <= 32'h1000_0000 + 32'(rom_addr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1ns past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // A push into a full FIFO must never be attempted.
   always @(negedge clk) begin
      if (rst_n === 1'b1)
         check("push_into_full",
               {31'b0, (dut.req_v && !redirect && (int'(dut.count) == DEPTH))}, 32'h0);
   end

   initial begin
      rst_n       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      id_ready    = 1'b1;
      #12;
      check("rst_valid", {31'b0, id_valid}, 32'h0);
      check("rst_instr", id_instr, 32'h0);
      check("rst_npc",   id_next_pc, 32'h0);
      check("rst_pc",    fetch_pc, 32'h0);

      // ---- Scenario 1: stream after reset release ----
      step();
      rst_n = 1'b1;
      step();                                   // E0: word 0 issued
      check("s1_e0_valid", {31'b0, id_valid}, 32'h0);
      check("s1_e0_pc", fetch_pc, 32'h4);
      for (int k = 0; k < 5; k++) begin
         step();                                // E(1+k)
         check("s1_valid", {31'b0, id_valid}, 32'h1);
         check("s1_instr", id_instr, 32'h1000_0000 + 32'(k));
         check("s1_npc",   id_next_pc, 32'(4 * (k + 1)));
         check("s1_pc",    fetch_pc, 32'(4 * (k + 2)));
      end

      // ---- Scenario 2: decode stall for 10 cycles ----
      id_ready = 1'b0;
      for (int c = 6; c <= 15; c++) begin
         step();
         check("s2_hold_valid", {31'b0, id_valid}, 32'h1);
         check("s2_hold_instr", id_instr, 32'h1000_0004);
         check("s2_hold_npc",   id_next_pc, 32'h14);
         if (c >= 7) check("s2_pc_stopped", fetch_pc, 32'h20);
      end
      id_ready = 1'b1;
      for (int j = 0; j < 8; j++) begin
         step();                                // E(16+j)
         check("s2_rel_valid", {31'b0, id_valid}, 32'h1);
         check("s2_rel_instr", id_instr, 32'h1000_0005 + 32'(j));
         check("s2_rel_npc",   id_next_pc, 32'(4 * (6 + j)));
      end

      // ---- Scenario 3: redirect with FIFO full ----
      id_ready = 1'b0;
      repeat (6) step();
      check("s3_full_head", id_instr, 32'h1000_000C);
      check("s3_full_pc",   fetch_pc, 32'h40);
      redirect    = 1'b1;
      redirect_pc = 32'h83;                     // low bits must be ignored
      step();                                   // edge N
      redirect = 1'b0;
      id_ready = 1'b1;
      check("s3_n0_valid", {31'b0, id_valid}, 32'h0);
      check("s3_n0_instr", id_instr, 32'h0);
      check("s3_n0_pc",    fetch_pc, 32'h80);
      step();                                   // N+1
      check("s3_n1_valid", {31'b0, id_valid}, 32'h0);
      check("s3_n1_pc",    fetch_pc, 32'h84);
      step();                                   // N+2
      check("s3_n2_valid", {31'b0, id_valid}, 32'h1);
      check("s3_n2_instr", id_instr, 32'h1000_0020);
      check("s3_n2_npc",   id_next_pc, 32'h84);
      step();                                   // N+3
      check("s3_n3_instr", id_instr, 32'h1000_0021);
      check("s3_n3_npc",   id_next_pc, 32'h88);

      // ---- Scenario 4: redirect with simultaneous pop and return ----
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      step();
      redirect = 1'b0;
      check("s4_n0_valid", {31'b0, id_valid}, 32'h0);
      check("s4_n0_pc",    fetch_pc, 32'h100);
      step();
      check("s4_n1_valid", {31'b0, id_valid}, 32'h0);
      step();
      check("s4_n2_valid", {31'b0, id_valid}, 32'h1);
      check("s4_n2_instr", id_instr, 32'h1000_0040);
      check("s4_n2_npc",   id_next_pc, 32'h104);
      step();
      check("s4_n3_instr", id_instr, 32'h1000_0041);

      // ---- Scenario 5: asynchronous reset between edges ----
      #3;
      rst_n = 1'b0;
      #1;
      check("s5_async_valid", {31'b0, id_valid}, 32'h0);
      check("s5_async_instr", id_instr, 32'h0);
      check("s5_async_npc",   id_next_pc, 32'h0);
      check("s5_async_pc",    fetch_pc, 32'h0);
      step();
      step();
      rst_n = 1'b1;
      step();                                   // E0
      check("s5_e0_valid", {31'b0, id_valid}, 32'h0);
      check("s5_e0_pc",    fetch_pc, 32'h4);
      step();                                   // E1
      check("s5_e1_valid", {31'b0, id_valid}, 32'h1);
      check("s5_e1_instr", id_instr, 32'h1000_0000);
      check("s5_e1_npc",   id_next_pc, 32'h4);
      step();                                   // E2
      check("s5_e2_instr", id_instr, 32'h1000_0001);
      check("s5_e2_npc",   id_next_pc, 32'h8);

`ifdef FETCH_PERF_EN
      // ---- Performance counters ----
      #3;
      rst_n = 1'b0;
      #1;
      check("perf_rst_fetch", perf_fetch, 32'h0);
      check("perf_rst_flush", {16'h0, perf_flush}, 32'h0);
      id_ready = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (4) step();
      id_ready = 1'b1;
      repeat (5) step();
      id_ready = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h0;
      repeat (2) step();
      redirect = 1'b0;
      check("perf_fetch_5", perf_fetch, 32'd5);
      check("perf_flush_2", {16'h0, perf_flush}, 32'd2);
      redirect = 1'b1;
      repeat (70000) step();
      redirect = 1'b0;
      check("perf_flush_sat", {16'h0, perf_flush}, 32'h0000_FFFF);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end for the 5-stage MIPS pipeline. It owns the program counter, drives the synchronous instruction ROM, and buffers returned instructions in a small FIFO ahead of the IF/ID latch, so decode can stall without losing fetched words. A taken branch resolved in MEM redirects fetch and flushes everything buffered or in flight.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥3 for full throughput
- AW, 10, ROM word-address width
- RESET_PC, 32'h0000_0000, byte address fetched first after reset

- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- redirect  in  1  taken branch from MEM; flush and reload
- redirect_pc  in  32  branch target byte address
- rom_addr  out  AW  word address to ROM, = pc[AW+1:2]
- rom_data  in  32  ROM read data, valid one cycle after rom_addr
- id_ready  in  1  IF/ID can accept this cycle
- id_valid  out  1  FIFO head holds an instruction
- id_instr  out  32  head instruction; 0 when !id_valid
- id_next_pc  out  32  head PC+4; 0 when !id_valid
- fetch_pc  out  32  current fetch PC register
- perf_fetch  out  32  delivered-instruction count (FETCH_PERF_EN only)
- perf_flush  out  16  redirect count (FETCH_PERF_EN only)

## Operation
- State: pc register, one in-flight slot (req_v, req_pc), FIFO of {pc+4, instr} with rd/wr pointers and count.
- Issue: in a cycle without redirect, issue iff count + req_v < DEPTH (registered values; a same-cycle pop gives no credit). On issue: req_v←1, req_pc←pc, pc←pc+4. Otherwise req_v←0 and pc holds.
- Return: if req_v, push {req_pc+4, rom_data} at end of cycle.
- Pop: id_valid && id_ready && !redirect → rd pointer advances.
- Push and pop together: count unchanged. Push to a full FIFO cannot happen under the issue rule; bench asserts it never does.
- Redirect (highest priority): count←0, pointers←0, req_v←0, pc←redirect_pc, no issue, no push, pop ignored. Data returning that cycle is discarded.
- Arithmetic: pc+4 wraps modulo 2^32; pointers wrap modulo DEPTH; redirect_pc[1:0] ignored (forced 0).
- Reset (async, any time): pc←RESET_PC, req_v←0, count/pointers←0, id_valid←0, id_instr/id_next_pc←0, perf counters←0, effective without a clock edge. In-flight ROM data is dropped.

## Timing
- Reset release before edge E0: issue in cycle 1 (rom_addr=RESET_PC[AW+1:2]), data in cycle 2, id_valid=1 in cycle 3.
- Redirect sampled at edge N: target issued in cycle N+1, pushed end of N+2, id_valid in N+3 (two bubble cycles after flush cycle).
- Steady state with id_ready=1: one instruction per cycle, count oscillates at 1.
- id_ready low: id_valid, id_instr, id_next_pc stable until popped; issue stops once count + req_v reaches DEPTH; resumes the cycle after first pop frees credit.
- Outputs derive from registered FIFO state only; no combinational path from rom_data or id_ready to id_valid/id_instr.

## Configuration
- FETCH_PERF_EN defined: perf_fetch increments on every pop (wraps at 2^32); perf_flush increments on every redirect, saturating at 16'hFFFF; both cleared by reset.
- Undefined: perf_fetch and perf_flush ports and counters are absent; all other behaviour identical.

## Test plan
- Reset release, RESET_PC=0, ROM word k = 32'h1000_0000+k, id_ready=1 -> id_valid first high cycle 3; id_instr 0x10000000, 0x10000001, … one per cycle; id_next_pc 0x4, 0x8, …
- Same stream, id_ready=0 for 10 cycles from cycle 5 -> head held constant, count reaches 4, fetch_pc stops advancing; on release, sequence continues with no gap, loss, or duplicate.
- FIFO full, redirect=1 with redirect_pc=0x40 -> id_valid low next cycle and next two cycles, then id_instr=0x10000010, id_next_pc=0x44.
- Redirect in same cycle as a pop and a returning request -> neither popped head nor returning word is delivered afterwards; first delivered is target word.
- rst_n low mid-stream between edges -> id_valid, id_instr, id_next_pc go 0 and fetch_pc=RESET_PC immediately; restart follows first scenario.
- FETCH_PERF_EN: 5 pops and 2 redirects -> perf_fetch=5, perf_flush=2; 70000 redirects -> perf_flush=0xFFFF. Without macro, build has no perf ports.
